hdmi_timing_gen: RTL and testbench

Video source for the HDMI transmit path. It generates raster timing (`tx_de`, `tx_hsync`, `tx_vsync`) and pixel data (`tx_rgb`) on the TX pixel clock, feeding the tx-side inputs of the HDMI matrix, which drive both `dvi_encoder_top` instances. Pixels come from an upstream stream (framebuffer/scaler) through a request/valid handshake, or from a built-in test pattern generator.

---
 rtl/hdmi_timing_gen.sv | 173 +++++++++++++++++
 tb/tb_hdmi_timing_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hdmi_timing_gen : HDMI TX raster timing plus stream / test-pattern source  |
// | Option macro    : HDMI_TIMING_GEN_PATTERN_EN (pattern generator, frame_cnt)|
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module hdmi_timing_gen #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        tx_pclk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_req,
  output logic [23:0] tx_rgb,
  output logic        tx_de,
  output logic        tx_hsync,
  output logic        tx_vsync,
  output logic        sof,
  output logic        underflow,
  output logic [15:0] underflow_cnt
);

  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] hcnt;
  logic [11:0] vcnt;
  logic        frame_start;
  logic        line_end;
  logic        frame_end;
  logic        active;
  logic        hs;
  logic        vs;
  logic [1:0]  pat_cur;
  logic [23:0] pix_pat;
  logic [23:0] pix_next;

  always_comb begin
    frame_start = (hcnt == 12'd0) && (vcnt == 12'd0);
    line_end    = (hcnt == H_LAST);
    frame_end   = line_end && (vcnt == V_LAST);
    active      = (hcnt < H_ACT) && (vcnt < V_ACT);
    hs          = (hcnt >= HS_START) && (hcnt < HS_END);
    vs          = (vcnt >= VS_START) && (vcnt < VS_END);
  end

`ifdef HDMI_TIMING_GEN_PATTERN_EN
  localparam logic [11:0] BAR_W = 12'(H_ACTIVE >> 3);

  logic [1:0]  pat_q;
  logic [7:0]  frame_cnt;
  logic [2:0]  bar_idx;
  logic [11:0] bar_pos;

  // The frame's first pixel already uses the newly sampled selection, so a
  // whole frame is always rendered with one pattern.
  assign pat_cur = frame_start ? pattern_sel : pat_q;

  always_ff @(posedge tx_pclk) begin
    if (rst) begin
      pat_q     <= 2'd0;
      frame_cnt <= 8'd0;
    end else if (en) begin
      if (frame_start) pat_q <= pattern_sel;
      if (frame_end) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Bar tracking without a divider; the final bar runs to the end of the line.
  always_ff @(posedge tx_pclk) begin
    if (rst || !en || line_end) begin
      bar_idx <= 3'd0;
      bar_pos <= 12'd0;
    end else if ((bar_pos == BAR_W - 12'd1) && (bar_idx != 3'd7)) begin
      bar_idx <= bar_idx + 3'd1;
      bar_pos <= 12'd0;
    end else begin
      bar_pos <= bar_pos + 12'd1;
    end
  end

  always_comb begin
    pix_pat = 24'h000000;
    case (pat_cur)
      2'd1: begin
        case (bar_idx)
          3'd0:    pix_pat = 24'hFFFFFF;
          3'd1:    pix_pat = 24'h00FFFF;
          3'd2:    pix_pat = 24'hFFFF00;
          3'd3:    pix_pat = 24'h00FF00;
          3'd4:    pix_pat = 24'hFF00FF;
          3'd5:    pix_pat = 24'h0000FF;
          3'd6:    pix_pat = 24'hFF0000;
          default: pix_pat = 24'h000000;
        endcase
      end
      2'd2:    pix_pat = (hcnt[4] ^ vcnt[4]) ? 24'hFFFFFF : 24'h000000;
      2'd3:    pix_pat = {frame_cnt, vcnt[7:0], hcnt[7:0]};
      default: pix_pat = 24'h000000;
    endcase
  end
`else
  logic unused_pattern_sel;

  assign unused_pattern_sel = ^pattern_sel;
  assign pat_cur            = 2'd0;
  assign pix_pat            = 24'h000000;
`endif

  assign pix_req = en && !rst && active && (pat_cur == 2'd0);

  always_comb begin
    pix_next = 24'h000000;
    if (active) begin
      if (pat_cur == 2'd0) pix_next = pix_valid ? pix_data : 24'h000000;
      else                 pix_next = pix_pat;
    end
  end

  always_ff @(posedge tx_pclk) begin
    if (rst) begin
      hcnt          <= 12'd0;
      vcnt          <= 12'd0;
      tx_rgb        <= 24'h000000;
      tx_de         <= 1'b0;
      tx_hsync      <= ~HS_POL;
      tx_vsync      <= ~VS_POL;
      sof           <= 1'b0;
      underflow     <= 1'b0;
      underflow_cnt <= 16'd0;
    end else if (!en) begin
      hcnt     <= 12'd0;
      vcnt     <= 12'd0;
      tx_rgb   <= 24'h000000;
      tx_de    <= 1'b0;
      tx_hsync <= ~HS_POL;
      tx_vsync <= ~VS_POL;
      sof      <= 1'b0;
    end else begin
      hcnt <= line_end ? 12'd0 : hcnt + 12'd1;
      if (line_end) vcnt <= (vcnt == V_LAST) ? 12'd0 : vcnt + 12'd1;
      tx_rgb   <= pix_next;
      tx_de    <= active;
      tx_hsync <= hs ? HS_POL : ~HS_POL;
      tx_vsync <= vs ? VS_POL : ~VS_POL;
      sof      <= frame_start;
      if (pix_req && !pix_valid) begin
        underflow <= 1'b1;
        if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_timing_gen.sv
`default_nettype none
// Testbench for hdmi_timing_gen: scoreboard against a position-based raster model,
// plus a large-raster instance driven to underflow counter saturation.
module tb_hdmi_timing_gen;

  localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int BW = HA >> 3;
  localparam int SA = 200;
  localparam int ST = 203;
`ifdef HDMI_TIMING_GEN_PATTERN_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                                       24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, en = 1'b0, pix_valid = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] pix_data = 24'd0;
  logic        pix_req, tx_de, tx_hsync, tx_vsync, sof, underflow;
  logic [23:0] tx_rgb;
  logic [15:0] underflow_cnt;

  logic        rst_s = 1'b1, en_s = 1'b0;
  logic        pix_req_s, tx_de_s, tx_hsync_s, tx_vsync_s, sof_s, underflow_s;
  logic [23:0] tx_rgb_s;
  logic [15:0] underflow_cnt_s;

  hdmi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .tx_pclk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_req(pix_req),
    .tx_rgb(tx_rgb), .tx_de(tx_de), .tx_hsync(tx_hsync), .tx_vsync(tx_vsync),
    .sof(sof), .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  hdmi_timing_gen #(
    .H_ACTIVE(SA), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(SA), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_sat (
    .tx_pclk(clk), .rst(rst_s), .en(en_s), .pattern_sel(2'd0),
    .pix_data(24'h123456), .pix_valid(1'b0), .pix_req(pix_req_s),
    .tx_rgb(tx_rgb_s), .tx_de(tx_de_s), .tx_hsync(tx_hsync_s), .tx_vsync(tx_vsync_s),
    .sof(sof_s), .underflow(underflow_s), .underflow_cnt(underflow_cnt_s)
  );

  typedef struct packed {
    logic        de, hs, vs, sof, uf;
    logic [15:0] ucnt;
    logic [23:0] rgb;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state: position is just the cycle index since the raster started
  int          k = 0, frame_no = 0, cur_pat = 0, ucnt_m = 0;
  bit          uf_m = 1'b0;
  bit          count_en = 1'b0;
  int          req_seen = 0, de_seen = 0, sof_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pat_pix(int p, int h, int v, int f);
    logic [7:0] fb, vb, hb;
    fb = 8'(f); vb = 8'(v); hb = 8'(h);
    case (p)
      1:       return BARS[(h / BW) > 7 ? 7 : (h / BW)];
      2:       return ((((h >> 4) ^ (v >> 4)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      3:       return {fb, vb, hb};
      default: return 24'h000000;
    endcase
  endfunction

  task automatic step(input logic r, input logic e, input logic [1:0] ps,
                      input logic [23:0] d, input logic val);
    exp_t x;
    bit   req_m, act;
    int   h, v;
    @(negedge clk);
    rst = r; en = e; pattern_sel = ps; pix_data = d; pix_valid = val;
    #1;
    req_m = 1'b0;
    x = '0;
    if (r) begin
      k = 0; frame_no = 0; uf_m = 1'b0; ucnt_m = 0; cur_pat = 0;
    end else if (!e) begin
      k = 0;
    end else begin
      h = k % HT;
      v = (k / HT) % VT;
      if (h == 0 && v == 0) cur_pat = PAT_EN ? int'(ps) : 0;
      act   = (h < HA) && (v < VA);
      req_m = act && (cur_pat == 0);
      x.de  = act;
      x.hs  = (h >= HA + HF) && (h < HA + HF + HSW);
      x.vs  = (v >= VA + VF) && (v < VA + VF + VSW);
      x.sof = (h == 0) && (v == 0);
      if (act) x.rgb = (cur_pat == 0) ? (val ? d : 24'h000000) : pat_pix(cur_pat, h, v, frame_no);
      if (req_m && !val) begin
        uf_m = 1'b1;
        if (ucnt_m < 65535) ucnt_m++;
      end
      if (h == HT - 1 && v == VT - 1) frame_no = (frame_no + 1) % 256;
      k++;
    end
    x.uf   = uf_m;
    x.ucnt = 16'(ucnt_m);
    chk("pix_req", {31'd0, pix_req}, {31'd0, req_m});
    if (count_en) begin
      if (pix_req) req_seen++;
      if (tx_de)   de_seen++;
      if (sof)     sof_seen++;
    end
    q.push_back(x);
  endtask

  // monitor: registered outputs of each issued cycle appear after the next rising edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("tx_de",         {31'd0, tx_de},    {31'd0, x.de});
        chk("tx_hsync",      {31'd0, tx_hsync}, {31'd0, x.hs});
        chk("tx_vsync",      {31'd0, tx_vsync}, {31'd0, x.vs});
        chk("sof",           {31'd0, sof},      {31'd0, x.sof});
        chk("tx_rgb",        {8'd0, tx_rgb},    {8'd0, x.rgb});
        chk("underflow",     {31'd0, underflow},{31'd0, x.uf});
        chk("underflow_cnt", {16'd0, underflow_cnt}, {16'd0, x.ucnt});
      end
    end
  end

  task automatic run_main();
    logic [23:0] cnt;
    logic [1:0]  seq [7];
    int          pos;
    seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd2};
    repeat (3) step(1'b1, 1'b0, 2'd0, 24'd0, 1'b0);
    repeat (20) step(1'b0, 1'b0, 2'($urandom), 24'($urandom), 1'($urandom));

    cnt = 24'd1;
    count_en = 1'b1;
    repeat (2 * HT * VT) begin
      step(1'b0, 1'b1, 2'd0, cnt, 1'b1);
      cnt++;
    end
    count_en = 1'b0;
    chk("req_per_2frames", req_seen, 2 * HA * VA);
    chk("de_per_2frames",  de_seen,  2 * HA * VA);
    chk("sof_per_2frames", sof_seen, 2);

    repeat (HT * VT) begin
      pos = k % (HT * VT);
      step(1'b0, 1'b1, 2'd0, cnt, !(pos == 3 || pos == 4 || pos == 17));
      cnt++;
    end
    chk("underflow_after_3", {31'd0, underflow}, 32'd1);
    chk("underflow_cnt_3",   {16'd0, underflow_cnt}, 32'd3);

    repeat (2 * HT * VT) step(1'b0, 1'b1, 2'd0, 24'($urandom), $urandom_range(0, 7) != 0);

    repeat (40) step(1'b0, 1'b1, 2'd0, 24'($urandom), 1'b1);
    repeat ($urandom_range(3, 10)) step(1'b0, 1'b0, 2'd0, 24'($urandom), 1'($urandom));
    repeat (60) step(1'b0, 1'b1, 2'd0, 24'($urandom), $urandom_range(0, 5) != 0);
    repeat (2) step(1'b1, 1'b1, 2'd0, 24'($urandom), 1'b1);

    for (int s = 0; s < 7; s++)
      repeat (150) step(1'b0, 1'b1, seq[s], 24'($urandom), $urandom_range(0, 9) != 0);
    repeat (4) step(1'b0, 1'b0, 2'd0, 24'd0, 1'b0);
    @(posedge clk);
    #2;
  endtask

  task automatic run_sat();
    int  ks, misses;
    bit  mid;
    ks = 0; misses = 0; mid = 1'b0;
    repeat (2) @(negedge clk);
    rst_s = 1'b0;
    en_s  = 1'b1;
    #1;
    while (misses < 70000 && ks < 80000) begin
      if (misses == 1000 && !mid) begin
        mid = 1'b1;
        chk("sat_cnt_1000", {16'd0, underflow_cnt_s}, 32'd1000);
      end
      if ((ks % ST) < SA && ((ks / ST) % ST) < SA) misses++;
      ks++;
      @(negedge clk);
      #1;
    end
    if (misses < 70000) begin
      errors++;
      $display("FAIL sat_budget: got %0d misses, want 70000", misses);
    end
    chk("sat_cnt_final", {16'd0, underflow_cnt_s}, (misses > 65535) ? 32'd65535 : 32'(misses));
    chk("sat_underflow", {31'd0, underflow_s}, 32'd1);
  endtask

  initial begin
    fork
      run_main();
      run_sat();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
